// File: rtl/dbg_probe_pkg.sv
// Shared definitions for the serial debug probe: command opcodes, reply codes,
// FSM state encoding and a channel range helper.
package dbg_probe_pkg;

    localparam logic [3:0] OP_READ      = 4'h0;
    localparam logic [3:0] OP_CLEAR     = 4'h1;
    localparam logic [3:0] OP_CLEAR_ALL = 4'h2;
    localparam logic [3:0] OP_INFO      = 4'h3;
    localparam logic [3:0] OP_STATUS    = 4'h4;

    localparam logic [7:0] ACK = 8'hA5;
    localparam logic [7:0] ERR = 8'hEE;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    function automatic logic ch_in_range(input logic [3:0] ch, input int unsigned num_ch);
        return ({28'd0, ch} < num_ch);
    endfunction

endpackage

// File: rtl/serial_dbg_probe_if.sv
// Command/response byte link between the probe and the UART receiver/transmitter.
interface serial_dbg_probe_if;

    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_ready;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       busy;

    modport master (
        output rx_valid, rx_data, tx_ready,
        input  tx_start, tx_data, busy
    );

    modport slave (
        input  rx_valid, rx_data, tx_ready,
        output tx_start, tx_data, busy
    );

endinterface

// File: rtl/dbg_event_counter.sv
// Single wrapping event counter; clear has priority over increment and the
// wrap strobe is registered one cycle after the roll-over to zero.
module dbg_event_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         wrap
);

    logic [W-1:0] count_r;
    logic         wrap_r;

    // Count register with clear-over-increment priority
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
            wrap_r  <= 1'b0;
        end else if (clr) begin
            count_r <= '0;
            wrap_r  <= 1'b0;
        end else if (inc) begin
            count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
            wrap_r  <= (count_r == {W{1'b1}});
        end else begin
            wrap_r  <= 1'b0;
        end
    end

    assign count = count_r;
    assign wrap  = wrap_r;

endmodule

// File: rtl/serial_dbg_probe.sv
// Byte-command debug probe: NUM_CH event counters that can be read, cleared and
// queried over a UART-style byte link, with sticky overflow/overrun status.
module serial_dbg_probe
    import dbg_probe_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ev,
    serial_dbg_probe_if.slave bus
);

    localparam int CNT_B = CNT_W / 8;
    localparam int BUF_N = (CNT_B < 2) ? 2 : CNT_B;
    localparam int IDX_W = $clog2(BUF_N);
    localparam int LEN_W = $clog2(BUF_N + 1);

    state_t           state_r;
    state_t           state_s;
    logic [7:0]       cmd_r;
    logic [7:0]       buf_r [BUF_N];
    logic [IDX_W-1:0] idx_r;
    logic [LEN_W-1:0] left_r;
    logic             gap_r;
    logic [7:0]       tx_hold_r;
    logic             ovf_any_r;
    logic             overrun_r;

    logic [CNT_W-1:0] cnt_s [NUM_CH];
    logic [NUM_CH-1:0] wrap_s;
    logic [NUM_CH-1:0] clr_s;
    logic [CNT_W-1:0] sel_cnt_s;
    logic [3:0]       op_s;
    logic [3:0]       ch_s;
    logic             ch_ok_s;
    logic [7:0]       load_buf_s [BUF_N];
    logic [LEN_W-1:0] load_len_s;
    logic             send_s;
    logic             status_clr_s;
    logic             overrun_set_s;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        dbg_event_counter #(.W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .inc   (ev[g]),
            .clr   (clr_s[g]),
            .count (cnt_s[g]),
            .wrap  (wrap_s[g])
        );
    end

    // Command decode, counter select and clear strobes (clears act in LOAD)
    always_comb begin
        op_s      = cmd_r[7:4];
        ch_s      = cmd_r[3:0];
        ch_ok_s   = ch_in_range(ch_s, NUM_CH);
        sel_cnt_s = '0;
        clr_s     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sel_cnt_s = sel_cnt_s | ({CNT_W{ch_s == 4'(i)}} & cnt_s[i]);
            clr_s[i]  = (state_r == ST_LOAD) &&
                        (((op_s == OP_CLEAR) && (ch_s == 4'(i))) || (op_s == OP_CLEAR_ALL));
        end
        status_clr_s  = (state_r == ST_LOAD) && (op_s == OP_STATUS);
        overrun_set_s = bus.rx_valid && (state_r != ST_IDLE);
    end

    // Reply contents and length for the latched command
    always_comb begin
        for (int k = 0; k < BUF_N; k++) begin
            load_buf_s[k] = 8'h00;
        end
        load_len_s = LEN_W'(1);
        case (op_s)
            OP_READ: begin
                if (ch_ok_s) begin
                    for (int k = 0; k < CNT_B; k++) begin
                        load_buf_s[k] = sel_cnt_s[CNT_W-1-8*k -: 8];
                    end
                    load_len_s = LEN_W'(CNT_B);
                end else begin
                    load_buf_s[0] = ERR;
                end
            end
            OP_CLEAR: begin
                if (ch_ok_s) begin
                    load_buf_s[0] = ACK;
                end else begin
                    load_buf_s[0] = ERR;
                end
            end
            OP_CLEAR_ALL: load_buf_s[0] = ACK;
            OP_INFO: begin
                load_buf_s[0] = 8'(NUM_CH);
                load_buf_s[1] = 8'(CNT_W);
                load_len_s    = LEN_W'(2);
            end
            OP_STATUS: load_buf_s[0] = {6'b000000, ovf_any_r, overrun_r};
            default:   load_buf_s[0] = ERR;
        endcase
    end

    // Next-state logic; tx_start is suppressed in any cycle with rst high
    always_comb begin
        state_s = state_r;
        send_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.rx_valid) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: state_s = ST_SEND;
            ST_SEND: begin
                if (bus.tx_ready) begin
                    send_s  = !rst;
                    state_s = ST_GAP;
                end else begin
                    state_s = ST_SEND;
                end
            end
            ST_GAP: begin
                if (!gap_r) begin
                    state_s = ST_GAP;
                end else if (left_r != '0) begin
                    state_s = ST_SEND;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Command latch, reply buffer snapshot and byte sequencing
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_r     <= 8'h00;
            idx_r     <= '0;
            left_r    <= '0;
            gap_r     <= 1'b0;
            tx_hold_r <= 8'h00;
            for (int k = 0; k < BUF_N; k++) begin
                buf_r[k] <= 8'h00;
            end
        end else begin
            if ((state_r == ST_IDLE) && bus.rx_valid) begin
                cmd_r <= bus.rx_data;
            end
            if (state_r == ST_LOAD) begin
                for (int k = 0; k < BUF_N; k++) begin
                    buf_r[k] <= load_buf_s[k];
                end
                idx_r  <= '0;
                left_r <= load_len_s;
            end else if (send_s) begin
                idx_r  <= idx_r + IDX_W'(1);
                left_r <= left_r - LEN_W'(1);
            end
            if (send_s) begin
                tx_hold_r <= buf_r[idx_r];
            end
            gap_r <= (state_r == ST_GAP) && !gap_r;
        end
    end

    // Sticky flags; a new event in the reply cycle survives the clear
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_any_r <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            if (|wrap_s) begin
                ovf_any_r <= 1'b1;
            end else if (status_clr_s) begin
                ovf_any_r <= 1'b0;
            end
            if (overrun_set_s) begin
                overrun_r <= 1'b1;
            end else if (status_clr_s) begin
                overrun_r <= 1'b0;
            end
        end
    end

    assign bus.tx_start = send_s;
    assign bus.tx_data  = send_s ? buf_r[idx_r] : tx_hold_r;
    assign bus.busy     = (state_r != ST_IDLE);

endmodule

// File: tb/tb_serial_dbg_probe.sv
// Self-checking bench for serial_dbg_probe: a reference counter model feeds an
// expected-byte queue that is drained and compared on every tx_start.
module tb_serial_dbg_probe;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] ev;

    serial_dbg_probe_if bus ();

    serial_dbg_probe #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .ev  (ev),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int               n_run  = 0;
    int               n_fail = 0;
    int               n_tx   = 0;
    logic [7:0]       exp_q [$];
    logic [CNT_W-1:0] model [NUM_CH];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every launched byte must match the head of the queue
    always @(negedge clk) begin
        if (bus.tx_start === 1'b1) begin
            n_tx++;
            check_eq("tx_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check_eq("tx_data", 32'(bus.tx_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ev[i]) model[i] = model[i] + 16'd1;
            end
        end
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] c);
        bus.rx_valid = 1'b1;
        bus.rx_data  = c;
        tick();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
    endtask

    task automatic push_read(input int ch);
        exp_q.push_back(model[ch][15:8]);
        exp_q.push_back(model[ch][7:0]);
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((exp_q.size() != 0 || bus.busy !== 1'b0) && k < 400) begin
            tick();
            k++;
        end
        if (k >= 400) check_eq("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_read(input int ch);
        send_cmd(8'(ch));
        push_read(ch);
        wait_idle();
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        ev           = '1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h30;
        repeat (3) tick();
        ev           = '0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        rst          = 1'b0;
        for (int i = 0; i < NUM_CH; i++) model[i] = '0;
        exp_q.delete();
    endtask

    initial begin
        int k;
        int n0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.tx_ready = 1'b1;
        ev           = '0;
        rst          = 1'b1;
        do_reset();
        @(negedge clk);
        check_eq("rst_tx_start", 32'(bus.tx_start), 32'd0);
        check_eq("rst_tx_data", 32'(bus.tx_data), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        do_read(0);

        // 300 events on channel 1, then READ with latency check
        ev[1] = 1'b1;
        repeat (300) tick();
        ev[1] = 1'b0;
        send_cmd(8'h01);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h2C);
        @(negedge clk);
        check_eq("lat_n1_no_start", 32'(bus.tx_start), 32'd0);
        check_eq("lat_n1_busy", 32'(bus.busy), 32'd1);
        tick();
        @(negedge clk);
        check_eq("lat_n2_start", 32'(bus.tx_start), 32'd1);
        wait_idle();

        // Coherent READ while ev[0] keeps counting across a byte boundary
        ev[0] = 1'b1;
        repeat (254) tick();
        send_cmd(8'h00);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        repeat (30) tick();
        ev[0] = 1'b0;
        wait_idle();
        do_read(0);

        // CLEAR coinciding with an event on the same channel
        ev[2] = 1'b1;
        repeat (5) tick();
        ev[2] = 1'b0;
        tick();
        ev[2] = 1'b1;
        send_cmd(8'h12);
        ev[2] = 1'b0;
        model[2] = '0;
        exp_q.push_back(8'hA5);
        wait_idle();
        do_read(2);

        // Illegal channel / undefined opcodes leave all counters alone
        send_cmd(8'h07); exp_q.push_back(8'hEE); wait_idle();
        send_cmd(8'h90); exp_q.push_back(8'hEE); wait_idle();
        send_cmd(8'h17); exp_q.push_back(8'hEE); wait_idle();
        for (int ch = 0; ch < NUM_CH; ch++) do_read(ch);

        // Transmitter not ready: reply held off
        bus.tx_ready = 1'b0;
        send_cmd(8'h30);
        exp_q.push_back(8'h04);
        exp_q.push_back(8'h10);
        repeat (4) begin
            tick();
            check_eq("txr_low_hold", 32'(bus.tx_start), 32'd0);
        end
        bus.tx_ready = 1'b1;
        wait_idle();

        // Overrun: second INFO while busy is dropped
        send_cmd(8'h30);
        exp_q.push_back(8'h04);
        exp_q.push_back(8'h10);
        check_eq("busy_load", 32'(bus.busy), 32'd1);
        send_cmd(8'h30);
        wait_idle();
        repeat (10) tick();
        send_cmd(8'h40); exp_q.push_back(8'h01); wait_idle();
        send_cmd(8'h40); exp_q.push_back(8'h00); wait_idle();

        // Channel 3 up to all-ones, then wrap
        ev[3] = 1'b1;
        repeat (65534) tick();
        send_cmd(8'h03);
        ev[3] = 1'b0;
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFF);
        wait_idle();
        ev[3] = 1'b1;
        tick();
        ev[3] = 1'b0;
        do_read(3);
        send_cmd(8'h40); exp_q.push_back(8'h02); wait_idle();
        send_cmd(8'h40); exp_q.push_back(8'h00); wait_idle();

        // Reset while the second reply byte is pending
        send_cmd(8'h03);
        exp_q.push_back(8'h00);
        k = 0;
        while (bus.tx_start !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) check_eq("abort_first_timeout", 32'(k), 32'd0);
        tick();
        bus.tx_ready = 1'b0;
        repeat (4) tick();
        n0 = n_tx;
        bus.tx_ready = 1'b1;
        do_reset();
        repeat (20) tick();
        check_eq("abort_no_tx", 32'(n_tx), 32'(n0));
        check_eq("abort_busy", 32'(bus.busy), 32'd0);
        check_eq("abort_tx_data", 32'(bus.tx_data), 32'd0);
        do_read(1);
        send_cmd(8'h40); exp_q.push_back(8'h00); wait_idle();

        check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_dbg_probe.md
SERIAL_DBG_PROBE -- requirements
Module: serial_dbg_probe

Interface
REQ-001 Parameter NUM_CH, default 4: number of event-counter channels, legal range 1..16.
REQ-002 Parameter CNT_W, default 16: counter width in bits, a multiple of 8, legal range 8..32.
REQ-003 clk  input  1  system clock; all logic is on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 ev  input  NUM_CH  per-channel event pulse; each cycle high adds 1 to that channel's counter.
REQ-006 rx_valid  input  1  one-cycle strobe: the command byte is on rx_data (uart_rx rcv).
REQ-007 rx_data  input  8  received command byte.
REQ-008 tx_ready  input  1  transmitter idle (uart_tx ready).
REQ-009 tx_start  output  1  one-cycle strobe that launches transmission of tx_data.
REQ-010 tx_data  output  8  response byte; stable from tx_start until the next tx_start.
REQ-011 busy  output  1  high while a response is pending or in transmission.

Function
REQ-012 A command byte SHALL be decoded as: opcode = rx_data[7:4], channel = rx_data[3:0].
REQ-013 Opcode 0x0 (READ): the engine SHALL send the counter of the addressed channel, CNT_W/8 bytes, MSB first.
REQ-014 The READ value SHALL be captured in the cycle after rx_valid, so that all bytes of one reply come from a single value.
REQ-015 Opcode 0x1 (CLEAR): the addressed counter SHALL be set to 0 in the cycle after rx_valid, and the engine SHALL reply with one byte, 0xA5.
REQ-016 Opcode 0x2 (CLEAR_ALL): all counters SHALL be set to 0, and the engine SHALL reply with 0xA5; the channel field is ignored.
REQ-017 Opcode 0x3 (INFO): the engine SHALL reply with two bytes, {NUM_CH[7:0]} followed by {CNT_W[7:0]}.
REQ-018 Opcode 0x4 (STATUS): the engine SHALL reply with one byte, {6'b0, ovf_any, overrun}, and clear both flags in that reply cycle.
REQ-019 An undefined opcode, or a channel >= NUM_CH on READ or CLEAR, SHALL produce the single reply 0xEE with no other side effect.
REQ-020 Counters SHALL wrap from all-ones to 0; a wrap on any channel SHALL set the sticky flag ovf_any.
REQ-021 When ev[i] and a clear of channel i occur in the same cycle, the clear SHALL win and the counter SHALL be 0.
REQ-022 rx_valid while busy=1 SHALL be dropped and SHALL set the sticky flag overrun; a dropped command has no side effect.
REQ-023 The FSM SHALL have the states IDLE, LOAD, SEND and GAP.
REQ-024 IDLE to LOAD SHALL occur on rx_valid.
REQ-025 In LOAD, the FSM SHALL capture the reply bytes and the byte count, then go to SEND.
REQ-026 In SEND with tx_ready=1, the FSM SHALL assert tx_start for one cycle and go to GAP.
REQ-027 GAP SHALL last 2 cycles, during which tx_ready is ignored; the FSM then goes to SEND if bytes remain, else to IDLE.
REQ-028 Latency: with tx_ready high, rx_valid in cycle n SHALL produce the first tx_start in cycle n+2.
REQ-029 busy SHALL be high in the LOAD, SEND and GAP states.

Reset
REQ-030 On rst, the FSM SHALL go to IDLE, and all counters, ovf_any and overrun SHALL be 0.
REQ-031 On rst, tx_start SHALL be 0, tx_data SHALL be 0x00 and busy SHALL be 0.
REQ-032 rst asserted mid-reply SHALL abort the reply; no further tx_start SHALL be issued.
REQ-033 ev and rx_valid SHALL be ignored in any cycle where rst=1.

Structure
REQ-034 A shared package dbg_probe_pkg SHALL hold the opcode constants (OP_READ, OP_CLEAR, OP_CLEAR_ALL, OP_INFO, OP_STATUS), the reply constants (ACK=0xA5, ERR=0xEE) and the FSM state encoding.
REQ-035 A sub-module dbg_event_counter (ports: clk, rst, inc, clr, count, wrap) SHALL be instantiated NUM_CH times.
REQ-036 The reply buffer SHALL be an array of CNT_W/8 bytes (minimum 2) plus a byte counter.

Verification
REQ-037 CNT_W=16: 300 ev[1] pulses, then command 0x01 -> tx bytes 0x01, 0x2C; first tx_start at n+2.
REQ-038 Hold ev[0] high across READ 0x00 -> the returned bytes form one coherent value equal to the count at n+1.
REQ-039 Command 0x12 in the same cycle as an ev[2] pulse -> reply 0xA5; then 0x02 returns 0x00, 0x00.
REQ-040 Commands 0x07 with NUM_CH=4, and 0x90 -> each replies 0xEE and no counter changes.
REQ-041 Send 0x30 then 0x30 again while busy -> reply 0x04, 0x10 only; a following 0x40 returns 0x01, then another 0x40 returns 0x00.
REQ-042 Force channel 3 to 0xFFFF, pulse ev[3] -> 0x03 returns 0x00, 0x00 and STATUS returns 0x02; rst during the second byte -> tx_start stays 0.
